// File: rtl/if_id_queue.sv
// if_id_queue: a small FIFO between the fetch (IF) and decode (ID) stages.
// It holds up to DEPTH (pc, inst) pairs. A redirect (flush) empties it.
//
// Handshake rules for both ports (strict valid/ready):
//   - A transfer happens on a rising edge only when valid=1, ready=1 and flush=0.
//   - if_ready depends only on the registered count. It never depends on id_ready,
//     so a full queue refuses a push even in a cycle that also pops.
//   - id_valid/id_pc/id_inst come straight from registers. With no entry queued,
//     id_pc and id_inst read as zero (a bubble).
//
// Optional feature: define IF_ID_QUEUE_PERF_EN to add a 32-bit saturating
// stall_cnt output. It counts edges where the head is valid but decode is
// not ready.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
`ifdef IF_ID_QUEUE_PERF_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic push;
  logic pop;

  // Status outputs and transfer qualifiers; flush suppresses both transfers.
  always_comb begin
    if_ready = (count < CNT_FULL);
    id_valid = (count != '0);
    push     = if_valid & if_ready & ~flush;
    pop      = id_valid & id_ready & ~flush;
  end

  // Head entry presented to decode, zeroed when the queue is empty.
  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (id_valid) begin
      id_pc   = pc_mem[head];
      id_inst = inst_mem[head];
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: cleared by reset, written at the tail on a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[tail]   <= if_pc;
      inst_mem[tail] <= if_inst;
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  // Decode back-pressure counter; saturates and ignores flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: bench for if_id_queue with DEPTH=2.
// A scoreboard queue holds the (pc, inst) entries the queue should contain.
// Build with IF_ID_QUEUE_PERF_EN defined to include the stall counter test.
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 2;
  localparam int E_W    = ADDR_W + INST_W;

  logic              clk;
  logic              rst;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [1:0]        count;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  int checks;
  int failures;

  // Scoreboard: {pc, inst} of every entry that should be in the queue, head first.
  logic [E_W-1:0] exp_q[$];
  int             pop_total;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
`ifdef IF_ID_QUEUE_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .count    (count)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, let one rising edge pass, and update the
  // scoreboard the way the queue is expected to change. Returns #1 after the edge.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] pc,
                       input logic [INST_W-1:0] inst, input logic rdy, input logic fl);
    int sz;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    sz = exp_q.size();
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rdy && sz != 0) begin
        void'(exp_q.pop_front());
        pop_total++;
      end
      if (v && sz < DEPTH) exp_q.push_back({pc, inst});
    end
    #1;
    if_valid = 1'b0;
    id_ready = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle_reset();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #13;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_pc !== '0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (id_inst !== '0) begin failures++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    logic [E_W-1:0] e;
    drive(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
    e = exp_q[0];
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL single_id_valid got=%b exp=1", id_valid); end
    checks++; if (id_pc !== e[E_W-1:INST_W]) begin failures++; $display("FAIL single_id_pc got=%h exp=%h", id_pc, e[E_W-1:INST_W]); end
    checks++; if (id_inst !== e[INST_W-1:0]) begin failures++; $display("FAIL single_id_inst got=%h exp=%h", id_inst, e[INST_W-1:0]); end
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_fill_full();
    logic [E_W-1:0] e;
    drive(1'b1, 32'h100, 32'hA000_0100, 1'b0, 1'b0);
    drive(1'b1, 32'h104, 32'hA000_0104, 1'b0, 1'b0);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL full_count got=%0d exp=2", count); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL full_if_ready got=%b exp=0", if_ready); end
    drive(1'b1, 32'h108, 32'hA000_0108, 1'b0, 1'b0);
    checks++; if (count !== 2'(exp_q.size())) begin failures++; $display("FAIL full_third_count got=%0d exp=%0d", count, exp_q.size()); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q[0];
      checks++; if (id_pc !== e[E_W-1:INST_W] || id_inst !== e[INST_W-1:0])
        begin failures++; $display("FAIL full_pop%0d got=%h/%h exp=%h/%h", k, id_pc, id_inst, e[E_W-1:INST_W], e[INST_W-1:0]); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL full_drain_count got=%0d exp=0", count); end
    checks++; if (id_pc !== '0) begin failures++; $display("FAIL full_drain_pc got=%h exp=0", id_pc); end
  endtask

  // Full push/pop streaming with simultaneous transfers; pointers wrap many times.
  task automatic test_streaming();
    logic [E_W-1:0] e;
    int start_pops;
    start_pops = pop_total;
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checks++; if (id_pc !== e[E_W-1:INST_W] || id_inst !== e[INST_W-1:0])
          begin failures++; $display("FAIL stream_head%0d got=%h/%h exp=%h/%h", i, id_pc, id_inst, e[E_W-1:INST_W], e[INST_W-1:0]); end
      end
      drive(1'b1, ADDR_W'(i * 4), INST_W'($urandom), 1'b1, 1'b0);
      checks++; if (count !== 2'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
    end
    e = exp_q[0];
    checks++; if (id_pc !== 32'h3C || id_pc !== e[E_W-1:INST_W]) begin failures++; $display("FAIL stream_last got=%h exp=%h", id_pc, e[E_W-1:INST_W]); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (pop_total - start_pops !== 16 || id_valid !== 1'b0)
      begin failures++; $display("FAIL stream_total pops=%0d valid=%b exp=16/0", pop_total - start_pops, id_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h110, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 32'h114, 32'h2, 1'b0, 1'b0);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
    drive(1'b1, 32'h200, 32'h3, 1'b1, 1'b1);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_id_valid got=%b exp=0", id_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (id_valid !== 1'b0 || id_pc === 32'h200)
        begin failures++; $display("FAIL flush_after%0d valid=%b pc=%h exp=0/not 200", i, id_valid, id_pc); end
    end
    // After a flush with non-zero pointers, a new push must still land correctly.
    drive(1'b1, 32'h120, 32'h4, 1'b0, 1'b0);
    checks++; if (id_pc !== 32'h120 || count !== 2'd1) begin failures++; $display("FAIL flush_repush pc=%h count=%0d exp=120/1", id_pc, count); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h130, 32'h5, 1'b0, 1'b0);
    checks++; if (count !== 2'd1) begin failures++; $display("FAIL arst_pre_count got=%0d exp=1", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || count !== 2'd0)
      begin failures++; $display("FAIL arst_immediate valid=%b count=%0d exp=0/0", id_valid, count); end
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    drive(1'b1, 32'h300, 32'h6, 1'b0, 1'b0);
    checks++; if (id_pc !== 32'h300 || id_valid !== 1'b1)
      begin failures++; $display("FAIL arst_repush pc=%h valid=%b exp=300/1", id_pc, id_valid); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

`ifdef IF_ID_QUEUE_PERF_EN
  task automatic test_perf();
    idle_reset();
    drive(1'b1, 32'h400, 32'h7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL perf_count got=%0d exp=5", stall_cnt); end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL perf_after_flush got=%0d exp=5", stall_cnt); end
    idle_reset();
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL perf_after_rst got=%0d exp=0", stall_cnt); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    pop_total = 0;
    rst       = 1'b0;
    test_reset();
    test_single_pass();
    test_fill_full();
    test_streaming();
    test_flush();
    test_async_reset();
`ifdef IF_ID_QUEUE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
